// File: rtl/psum_acc_pkg.sv
// Shared field layout and helpers for the psum accumulator: the info/data beat
// slices, the accumulator and output widths, and the beat-sum arithmetic.
package psum_acc_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 8;

  localparam int unsigned PIX_LSB   = 0;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned OCH_LSB   = 16;
  localparam int unsigned OCH_W     = 8;
  localparam int unsigned FIRST_BIT = 24;
  localparam int unsigned LAST_BIT  = 25;

  localparam int unsigned P3_LSB = 0;
  localparam int unsigned P3_W   = 32;
  localparam int unsigned P1_LSB = 32;
  localparam int unsigned P1_W   = 24;
  localparam int unsigned ID_LSB = 56;
  localparam int unsigned ID_W   = 8;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic [OCH_W-1:0] och;
    logic             first;
    logic             last;
  } beat_info_t;

  function automatic beat_info_t decode_info(input logic [31:0] raw);
    beat_info_t b;
    b.pix   = raw[PIX_LSB +: PIX_W];
    b.och   = raw[OCH_LSB +: OCH_W];
    b.first = raw[FIRST_BIT];
    b.last  = raw[LAST_BIT];
    return b;
  endfunction

  // Sum of the three signed beat lanes, each sign-extended to ACC_W, wrapping.
  function automatic logic [ACC_W-1:0] beat_sum(input logic [63:0] d);
    logic [ACC_W-1:0] p3;
    logic [ACC_W-1:0] p1;
    logic [ACC_W-1:0] id;
    p3 = d[P3_LSB +: P3_W];
    p1 = {{(ACC_W-P1_W){d[P1_LSB+P1_W-1]}}, d[P1_LSB +: P1_W]};
    id = {{(ACC_W-ID_W){d[ID_LSB+ID_W-1]}}, d[ID_LSB +: ID_W]};
    return p3 + p1 + id;
  endfunction

endpackage

// File: rtl/psum_acc_requant.sv
// Combinational requantizer: arithmetic right shift, signed saturation to OUT_W,
// and a ReLU clamp when PSUM_ACC_RELU_EN is defined.
module psum_acc_requant
  import psum_acc_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  input  logic [4:0]       shift_i,
  output logic [OUT_W-1:0] q_o
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] clamped;

  always_comb begin
    shifted = $signed(acc_i) >>> shift_i;
    if (shifted > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      clamped = SAT_MIN;
    end else begin
      clamped = shifted;
    end
`ifdef PSUM_ACC_RELU_EN
    if (clamped[ACC_W-1]) begin
      clamped = '0;
    end
`endif
    q_o = clamped[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_acc.sv
// Partial-sum accumulator between mac_array and the omap buffer: accumulates beats
// per pixel across input channels, requantizes on the last one (PSUM_ACC_RELU_EN selects ReLU).
module psum_acc
  import psum_acc_pkg::*;
#(
  parameter int unsigned MAP_DEPTH = 4096,
  parameter int unsigned AW        = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        conv_start,
  input  logic [7:0]  out_ch,
  input  logic [15:0] map_size,
  input  logic [4:0]  out_shift,
  input  logic [31:0] mac_array2psum_acc_info,
  input  logic [63:0] mac_array2psum_acc_data,
  input  logic        mac_array2psum_acc_vld,
  output logic        mac_array2psum_acc_rdy,
  output logic [31:0] omap_waddr,
  output logic [7:0]  omap_wdata,
  output logic        omap_vld,
  input  logic        omap_rdy,
  output logic        acc_done
);

  beat_info_t       info;
  logic [AW-1:0]    pix;
  logic [ACC_W-1:0] beat_s;
  logic [ACC_W-1:0] acc_sum;
  logic [OUT_W-1:0] requant_res;
  logic             accept;
  logic             omap_hs;
  logic [23:0]      total;

  logic [ACC_W-1:0] acc_buf_q [MAP_DEPTH];

  logic             active_q;
  logic             omap_vld_q, omap_vld_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [OUT_W-1:0] wdata_q, wdata_d;
  logic [23:0]      emitted_q, emitted_d;
  logic             done_q, done_d;

  logic unused_bits;
  assign unused_bits = ^{mac_array2psum_acc_info[31:26], info.pix[PIX_W-1:AW]};

  assign info    = decode_info(mac_array2psum_acc_info);
  assign pix     = info.pix[AW-1:0];
  assign beat_s  = beat_sum(mac_array2psum_acc_data);
  assign total   = 24'(out_ch) * 24'(map_size);

  // The output slot frees in the same cycle it hands off, so rdy follows omap_rdy.
  assign mac_array2psum_acc_rdy = active_q && (!omap_vld_q || omap_rdy);
  assign accept  = mac_array2psum_acc_vld && mac_array2psum_acc_rdy;
  assign omap_hs = omap_vld_q && omap_rdy;

  // Buffer write lands on the edge, so a following same-pixel beat reads it directly.
  assign acc_sum = info.first ? beat_s : acc_buf_q[pix] + beat_s;

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_buf_q[pix] <= acc_sum;
    end
  end

  psum_acc_requant u_requant (
    .acc_i   (acc_sum),
    .shift_i (out_shift),
    .q_o     (requant_res)
  );

  always_comb begin
    omap_vld_d = omap_vld_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (omap_hs) begin
      omap_vld_d = 1'b0;
    end
    if (accept && info.last) begin
      omap_vld_d = 1'b1;
      waddr_d    = 32'(info.och) * 32'(map_size) + 32'(pix);
      wdata_d    = requant_res;
    end
  end

  always_comb begin
    emitted_d = emitted_q;
    done_d    = 1'b0;
    if (conv_start) begin
      emitted_d = '0;
    end else if (omap_hs) begin
      if ((total != '0) && (emitted_q + 24'd1 == total)) begin
        emitted_d = '0;
        done_d    = 1'b1;
      end else begin
        emitted_d = emitted_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      omap_vld_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      emitted_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      active_q   <= 1'b1;
      omap_vld_q <= omap_vld_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      emitted_q  <= emitted_d;
      done_q     <= done_d;
    end
  end

  assign omap_vld   = omap_vld_q;
  assign omap_waddr = waddr_q;
  assign omap_wdata = wdata_q;
  assign acc_done   = done_q;

endmodule

// File: tb/tb_psum_acc.sv
// Self-checking bench for psum_acc: directed scenarios plus randomized layers
// checked against a per-pixel accumulate/requantize reference model.
module tb_psum_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conv_start = 1'b0;
  logic [7:0]  out_ch = '0;
  logic [15:0] map_size = '0;
  logic [4:0]  out_shift = '0;
  logic [31:0] info = '0;
  logic [63:0] data = '0;
  logic        vld = 1'b0;
  logic        rdy;
  logic [31:0] omap_waddr;
  logic [7:0]  omap_wdata;
  logic        omap_vld;
  logic        omap_rdy = 1'b1;
  logic        acc_done;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;

  logic [31:0] got_addr[$];
  logic [7:0]  got_data[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  int          acc_m[int];

  psum_acc #(.MAP_DEPTH(4096), .AW(12)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .conv_start              (conv_start),
    .out_ch                  (out_ch),
    .map_size                (map_size),
    .out_shift               (out_shift),
    .mac_array2psum_acc_info (info),
    .mac_array2psum_acc_data (data),
    .mac_array2psum_acc_vld  (vld),
    .mac_array2psum_acc_rdy  (rdy),
    .omap_waddr              (omap_waddr),
    .omap_wdata              (omap_wdata),
    .omap_vld                (omap_vld),
    .omap_rdy                (omap_rdy),
    .acc_done                (acc_done)
  );

  always #5 clk = ~clk;

  // Record every result handshake that the coming rising edge will complete.
  always @(negedge clk) begin
    if (rst_n && omap_vld && omap_rdy) begin
      got_addr.push_back(omap_waddr);
      got_data.push_back(omap_wdata);
    end
    if (acc_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] make_info(input int pix, input int och, input bit first, input bit last);
    return {6'b0, last, first, 8'(och), 16'(pix)};
  endfunction

  function automatic int beat_value(input logic [63:0] d);
    int p3, p1, id;
    p3 = int'($signed(d[31:0]));
    p1 = int'($signed(d[55:32]));
    id = int'($signed(d[63:56]));
    return p3 + p1 + id;
  endfunction

  function automatic logic [7:0] ref_requant(input int x, input int sh);
    int y;
    y = x >>> sh;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
`ifdef PSUM_ACC_RELU_EN
    if (y < 0) y = 0;
`endif
    return 8'(y);
  endfunction

  task automatic model_beat(input logic [31:0] inf, input logic [63:0] d);
    int key;
    int s;
    key = int'(inf[11:0]);
    s = beat_value(d);
    if (inf[24]) acc_m[key] = s;
    else acc_m[key] = acc_m[key] + s;
    if (inf[25]) begin
      exp_addr.push_back(32'(int'(inf[23:16]) * int'(map_size) + key));
      exp_data.push_back(ref_requant(acc_m[key], int'(out_shift)));
    end
  endtask

  task automatic put_beat(input logic [31:0] inf, input logic [63:0] d);
    bit ok;
    ok = 1'b0;
    vld = 1'b1; info = inf; data = d;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (rdy) ok = 1'b1;
      step();
    end
    vld = 1'b0;
    if (ok) model_beat(inf, d);
    else begin
      checks++;
      $display("FAIL beat_accept_timeout info=%h", inf);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (got_addr.size() >= exp_addr.size() && !omap_vld) ok = 1'b1;
      else step();
    end
  endtask

  task automatic clear_q();
    got_addr.delete(); got_data.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic pulse_start();
    conv_start = 1'b1;
    step();
    conv_start = 1'b0;
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vld = 1'b0; omap_rdy = 1'b1;
    repeat (2) step();
    checks++;
    if ({rdy, omap_vld, acc_done, omap_waddr, omap_wdata} !== 43'd0)
      $display("FAIL reset_outputs got rdy=%b vld=%b done=%b addr=%h data=%h required all 0",
               rdy, omap_vld, acc_done, omap_waddr, omap_wdata);
    else passed++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b0) $display("FAIL rdy_at_release got=%b required=0", rdy); else passed++;
    step();
    checks++;
    if (rdy !== 1'b1 || omap_vld !== 1'b0)
      $display("FAIL rdy_after_release got rdy=%b vld=%b required rdy=1 vld=0", rdy, omap_vld);
    else passed++;
  endtask

  task automatic test_single();
    bit ok;
    clear_q();
    out_ch = 8'd0; map_size = 16'd16; out_shift = 5'd2;
    put_beat(make_info(5, 2, 1'b1, 1'b1), {8'd4, 24'hFFFFD4, 32'd300});
    checks++;
    if (omap_vld !== 1'b1 || omap_waddr !== 32'd37 || omap_wdata !== 8'd65)
      $display("FAIL single_beat got vld=%b addr=%0d data=%0d required vld=1 addr=37 data=65",
               omap_vld, omap_waddr, omap_wdata);
    else passed++;
    wait_drain(ok);
    checks++;
    if (!ok || got_addr.size() != 1)
      $display("FAIL single_count got=%0d required=1", got_addr.size());
    else passed++;
  endtask

  task automatic test_multi_ic();
    bit ok;
    logic [7:0] want [2];
    want[0] = 8'd93;
    want[1] = 8'd127;
    for (int r = 0; r < 2; r++) begin
      clear_q();
      out_ch = 8'd0; map_size = 16'd1; out_shift = (r == 0) ? 5'd5 : 5'd4;
      put_beat(make_info(0, 0, 1'b1, 1'b0), 64'd1000);
      put_beat(make_info(0, 0, 1'b0, 1'b0), 64'd1000);
      put_beat(make_info(0, 0, 1'b0, 1'b1), 64'd1000);
      wait_drain(ok);
      checks++;
      if (!ok || got_data.size() != 1 || got_data[0] !== want[r] || got_addr[0] !== 32'd0)
        $display("FAIL multi_ic_%0d got n=%0d data=%0d required n=1 data=%0d",
                 r, got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'd0, want[r]);
      else passed++;
    end
  endtask

  task automatic test_negative();
    bit ok;
    logic [7:0] want;
`ifdef PSUM_ACC_RELU_EN
    want = 8'd0;
`else
    want = 8'h80;
`endif
    clear_q();
    out_ch = 8'd0; map_size = 16'd4; out_shift = 5'd3;
    put_beat(make_info(3, 0, 1'b1, 1'b1), {32'd0, 32'hFFFFF000});
    wait_drain(ok);
    checks++;
    if (!ok || got_data.size() != 1 || got_data[0] !== want)
      $display("FAIL negative_sat got n=%0d data=%h required data=%h",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'd0, want);
    else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    clear_q();
    out_ch = 8'd0; map_size = 16'd16; out_shift = 5'd0;
    omap_rdy = 1'b0;
    put_beat(make_info(1, 1, 1'b1, 1'b1), 64'd10);
    vld = 1'b1; info = make_info(2, 1, 1'b1, 1'b1); data = 64'd20;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rdy !== 1'b0 || omap_vld !== 1'b1 || omap_waddr !== 32'd17 || omap_wdata !== 8'd10) bad++;
      step();
    end
    checks++;
    if (bad != 0) $display("FAIL hold_stable bad_cycles=%0d required=0", bad); else passed++;
    omap_rdy = 1'b1;
    #1;
    checks++;
    if (rdy !== 1'b1) $display("FAIL rdy_on_return got=%b required=1", rdy); else passed++;
    step();
    vld = 1'b0;
    checks++;
    if (omap_vld !== 1'b1 || omap_waddr !== 32'd18 || omap_wdata !== 8'd20)
      $display("FAIL second_result got vld=%b addr=%0d data=%0d required vld=1 addr=18 data=20",
               omap_vld, omap_waddr, omap_wdata);
    else passed++;
    step();
    checks++;
    if (got_addr.size() != 2 || got_addr[0] !== 32'd17 || got_data[0] !== 8'd10 ||
        got_addr[1] !== 32'd18 || got_data[1] !== 8'd20)
      $display("FAIL bp_order got n=%0d required n=2 (17/10, 18/20)", got_addr.size());
    else passed++;
  endtask

  task automatic run_layer(input int n_och, input int n_pix, input int n_ic, input bit rand_rdy);
    bit ok;
    bit stop;
    logic [63:0] d;
    stop = 1'b0;
    pulse_start();
    clear_q();
    fork
      begin
        for (int o = 0; o < n_och; o++)
          for (int ic = 0; ic < n_ic; ic++)
            for (int p = 0; p < n_pix; p++) begin
              d = {8'($urandom), 24'(int'($urandom_range(0, 65535)) - 32768),
                   32'(int'($urandom_range(0, 524288)) - 262144)};
              put_beat(make_info(p, o, ic == 0, ic == n_ic - 1), d);
            end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          if (rand_rdy) omap_rdy = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    omap_rdy = 1'b1;
    wait_drain(ok);
    repeat (3) step();
    checks++;
    if (!ok || got_addr.size() != exp_addr.size())
      $display("FAIL layer_count got=%0d required=%0d", got_addr.size(), exp_addr.size());
    else passed++;
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
        $display("FAIL layer_result_%0d got addr=%0d data=%0d required addr=%0d data=%0d",
                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      else passed++;
    end
    checks++;
    if (done_cnt != 1) $display("FAIL acc_done_pulses got=%0d required=1", done_cnt); else passed++;
  endtask

  task automatic test_sequence();
    for (int r = 0; r < 2; r++) begin
      out_ch = 8'd2; map_size = 16'd3; out_shift = 5'(10 + r);
      run_layer(2, 3, 1, 1'b0);
      for (int i = 0; i < 6 && i < got_addr.size(); i++) begin
        checks++;
        if (got_addr[i] !== 32'(i))
          $display("FAIL seq_addr_%0d got=%0d required=%0d", i, got_addr[i], i);
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    int no, np, ni;
    for (int r = 0; r < 4; r++) begin
      no = $urandom_range(1, 3);
      np = $urandom_range(1, 6);
      ni = $urandom_range(1, 3);
      out_ch = 8'(no); map_size = 16'(np); out_shift = 5'($urandom_range(8, 14));
      run_layer(no, np, ni, 1'b1);
    end
  endtask

  task automatic test_zero_size();
    bit ok;
    out_ch = 8'd0; map_size = 16'd4; out_shift = 5'd0;
    pulse_start();
    clear_q();
    for (int p = 0; p < 4; p++) put_beat(make_info(p, 0, 1'b1, 1'b1), 64'(p));
    wait_drain(ok);
    repeat (3) step();
    checks++;
    if (!ok || done_cnt != 0 || got_addr.size() != 4)
      $display("FAIL zero_size got done=%0d n=%0d required done=0 n=4", done_cnt, got_addr.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    omap_rdy = 1'b0;
    out_ch = 8'd0; map_size = 16'd8; out_shift = 5'd0;
    put_beat(make_info(6, 1, 1'b1, 1'b1), 64'd33);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, omap_vld, acc_done, omap_waddr, omap_wdata} !== 43'd0)
      $display("FAIL reset_mid got rdy=%b vld=%b addr=%h data=%h required all 0",
               rdy, omap_vld, omap_waddr, omap_wdata);
    else passed++;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    omap_rdy = 1'b1;
    #1;
    checks++;
    if (omap_vld !== 1'b0 || rdy !== 1'b1)
      $display("FAIL reset_mid_recover got vld=%b rdy=%b required vld=0 rdy=1", omap_vld, rdy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_ic();
    test_negative();
    test_backpressure();
    test_sequence();
    test_random();
    test_zero_size();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
